// File: rtl/biset_status_fifo_pkg.sv
// biset_status_fifo_pkg: BiSet bus types, the FIFO status-word layout and its
// bit positions. Imported by biset_fifo_core and biset_status_fifo.
package biset_status_fifo_pkg;

  // Status word bit positions (must match the BiSetFifoStatus struct below)
  localparam int COUNT_LSB = 0;
  localparam int EMPTY_BIT = 16;
  localparam int FULL_BIT  = 17;
  localparam int OVF_BIT   = 18;
  localparam int UDF_BIT   = 19;

  // BiSet request as seen by a slave: address plus read/write strobes
  typedef struct packed {
    logic [15:0] addr;
    logic        rd;
    logic        wr;
    logic [31:0] wdata;
  } biSetCtrl;

  // BiSet slave reply; all-zero when idle so replies can be OR-combined
  typedef struct packed {
    logic        valid;
    logic [31:0] data;
  } biSetReply;

  // Status word returned at ADDR+1
  typedef struct packed {
    logic [11:0] rsvd;
    logic        udf;    // bit 19
    logic        ovf;    // bit 18
    logic        full;   // bit 17
    logic        empty;  // bit 16
    logic [15:0] count;  // bits 15:0
  } BiSetFifoStatus;

endpackage

// File: rtl/biset_fifo_core.sv
// biset_fifo_core: generic synchronous circular-buffer FIFO.
// A push while full is accepted only if a pop happens in the same cycle;
// a pop while empty is ignored (no bypass of a same-cycle push).
// Handshake: push_i/pop_i are requests; the core itself decides acceptance
// from the registered count, so callers never need a ready signal.
module biset_fifo_core
  import biset_status_fifo_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH):0]     count_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full_q, full_d;
  logic             push_ok, pop_ok;

  assign empty_o = (count_q == '0);
  assign pop_ok  = pop_i && !empty_o;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts
  assign push_ok = push_i && (!full_q || pop_ok);

  // Next-state pointers, count and storage
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = wdata_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    full_d = (count_d == CW'(DEPTH));
  end

  // Control state registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= full_d;
    end
  end

  // Storage array; contents are only observed when count > 0, so no reset
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = full_q;

endmodule

// File: rtl/biset_status_fifo.sv
// biset_status_fifo: captures val_i into a DEPTH-entry FIFO on update_i and
// exposes it on the BiSet bus. ADDR reads pop the head, ADDR+1 reads the
// status word (count, empty, full, sticky ovf/udf; read-to-clear).
// Optional build macro BISET_STATUS_FIFO_DROPCNT_EN adds a 16-bit saturating
// dropped-push counter at ADDR+2 (read-to-clear).
// Bus handshake: setCtrl_i.rd is a one-cycle read strobe; the reply carries
// valid=1 for exactly one cycle, one cycle later. BiSet writes are ignored.
module biset_status_fifo
  import biset_status_fifo_pkg::*;
#(
  parameter int          ADDR  = 0,
  parameter int          WIDTH = 32,
  parameter int          DEPTH = 4,
  parameter logic [31:0] RESET = 32'h0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [WIDTH-1:0] val_i,
  input  logic             update_i,
  output logic             event_o,
  output logic             full_o,
  input  biSetCtrl         setCtrl_i,
  output biSetReply        setReply_o
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic             rd_data, rd_stat, rd_drop;
  logic [WIDTH-1:0] head;
  logic [CW-1:0]    count;
  logic             fifo_full, fifo_empty;
  logic             ovf_set, udf_set;
  logic             ovf_q, ovf_d;
  logic             udf_q, udf_d;
  logic             event_q, event_d;
  biSetReply        reply_q, reply_d;
  BiSetFifoStatus   status_w;
  logic [31:0]      drop_word;
  logic             unused_ctrl;

  // Writes carry nothing this block uses
  assign unused_ctrl = ^{setCtrl_i.wr, setCtrl_i.wdata};

  assign rd_data = setCtrl_i.rd && (setCtrl_i.addr == 16'(ADDR));
  assign rd_stat = setCtrl_i.rd && (setCtrl_i.addr == 16'(ADDR + 1));

  biset_fifo_core #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_core (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (update_i),
    .pop_i   (rd_data),
    .wdata_i (val_i),
    .rdata_o (head),
    .count_o (count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Overflow only when full and no same-cycle pop frees a slot
  assign ovf_set = update_i && fifo_full && !rd_data;
  assign udf_set = rd_data && fifo_empty;

`ifdef BISET_STATUS_FIFO_DROPCNT_EN
  logic [15:0] drop_cnt_q, drop_cnt_d;

  assign rd_drop   = setCtrl_i.rd && (setCtrl_i.addr == 16'(ADDR + 2));
  assign drop_word = 32'(drop_cnt_q);

  // Saturating drop counter; a read clears it, a drop in the read cycle counts as 1
  always_comb begin
    drop_cnt_d = drop_cnt_q;
    if (rd_drop) begin
      drop_cnt_d = ovf_set ? 16'd1 : 16'd0;
    end else if (ovf_set && (drop_cnt_q != 16'hFFFF)) begin
      drop_cnt_d = drop_cnt_q + 16'd1;
    end
  end

  // Drop counter register
  always_ff @(posedge clk_i) begin
    if (!rst_i) drop_cnt_q <= '0;
    else        drop_cnt_q <= drop_cnt_d;
  end
`else
  assign rd_drop   = 1'b0;
  assign drop_word = 32'h0;
`endif

  // Status word from current (pre-update) state
  always_comb begin
    status_w       = '0;
    status_w.count = 16'(count);
    status_w.empty = fifo_empty;
    status_w.full  = fifo_full;
    status_w.ovf   = ovf_q;
    status_w.udf   = udf_q;
  end

  // Sticky flags, empty->non-empty event and the next bus reply
  always_comb begin
    ovf_d   = (ovf_q && !rd_stat) || ovf_set;
    udf_d   = (udf_q && !rd_stat) || udf_set;
    event_d = update_i && fifo_empty;
    reply_d = '0;
    if (rd_data) begin
      reply_d.valid = 1'b1;
      reply_d.data  = fifo_empty ? RESET : 32'(head);
    end else if (rd_stat) begin
      reply_d.valid = 1'b1;
      reply_d.data  = status_w;
    end else if (rd_drop) begin
      reply_d.valid = 1'b1;
      reply_d.data  = drop_word;
    end
  end

  // Registered flags, event and reply; reset dominates
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ovf_q   <= 1'b0;
      udf_q   <= 1'b0;
      event_q <= 1'b0;
      reply_q <= '0;
    end else begin
      ovf_q   <= ovf_d;
      udf_q   <= udf_d;
      event_q <= event_d;
      reply_q <= reply_d;
    end
  end

  assign event_o    = event_q;
  assign full_o     = fifo_full;
  assign setReply_o = reply_q;

endmodule

// File: tb/tb_biset_status_fifo.sv
// tb_biset_status_fifo: directed test-plan steps followed by randomized
// traffic, each cycle checked against a queue-based model of the FIFO.
`timescale 1ns/1ps
module tb_biset_status_fifo;
  import biset_status_fifo_pkg::*;

  localparam int          ADDR  = 'h40;
  localparam int          WIDTH = 16;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RESET = 32'h1244;
  localparam logic [15:0] A_DAT = 16'(ADDR);
  localparam logic [15:0] A_STA = 16'(ADDR + 1);
  localparam logic [15:0] A_DRP = 16'(ADDR + 2);

  // ---------------- clock / reset ----------------
  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] val;
  logic             update;
  logic             event_w;
  logic             full_w;
  biSetCtrl         ctrl;
  biSetReply        reply;

  always #5 clk = ~clk;

  biset_status_fifo #(
    .ADDR  (ADDR),
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .RESET (RESET)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .val_i      (val),
    .update_i   (update),
    .event_o    (event_w),
    .full_o     (full_w),
    .setCtrl_i  (ctrl),
    .setReply_o (reply)
  );

  // ---------------- scoreboard / model ----------------
  logic [31:0] exp_q[$];
  bit          m_ovf;
  bit          m_udf;
  int          m_drop;
  int          n_checks;
  int          n_pass;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // ---------------- driver ----------------
  // Drive one cycle, advance the model on the edge, then check all outputs.
  task automatic step(input logic rst_v, input logic upd, input logic [WIDTH-1:0] v,
                      input logic rd, input logic [15:0] addr);
    logic [31:0] e_data;
    logic        e_valid, e_event, e_full;
    bit          empty, full, drd, srd, xrd, drop;
    rst_n      = rst_v;
    update     = upd;
    val        = v;
    ctrl.rd    = rd;
    ctrl.addr  = addr;
    ctrl.wr    = 1'($urandom_range(0, 1));
    ctrl.wdata = $urandom;
    @(posedge clk);
    e_valid = 1'b0;
    e_data  = 32'h0;
    e_event = 1'b0;
    if (!rst_v) begin
      exp_q.delete();
      m_ovf  = 1'b0;
      m_udf  = 1'b0;
      m_drop = 0;
    end else begin
      empty = (exp_q.size() == 0);
      full  = (exp_q.size() == DEPTH);
      drd   = rd && (addr == A_DAT);
      srd   = rd && (addr == A_STA);
      xrd   = 1'b0;
`ifdef BISET_STATUS_FIFO_DROPCNT_EN
      xrd   = rd && (addr == A_DRP);
`endif
      e_valid = drd || srd || xrd;
      if (drd) e_data = empty ? RESET : exp_q[0];
      if (srd) e_data = exp_q.size() + (empty ? 32'h10000 : 0) + (full ? 32'h20000 : 0)
                        + (m_ovf ? 32'h40000 : 0) + (m_udf ? 32'h80000 : 0);
      if (xrd) e_data = m_drop;
      drop    = upd && full && !drd;
      e_event = upd && empty;
      if (drd && !empty) void'(exp_q.pop_front());
      if (upd && !drop) exp_q.push_back(32'(v));
      if (srd) begin
        m_ovf = 1'b0;
        m_udf = 1'b0;
      end
      if (drop) m_ovf = 1'b1;
      if (drd && empty) m_udf = 1'b1;
      if (xrd) m_drop = drop ? 1 : 0;
      else if (drop && m_drop < 65535) m_drop++;
    end
    e_full = (exp_q.size() == DEPTH);
    #1;
    check("reply_valid", 32'(reply.valid), 32'(e_valid));
    check("reply_data", reply.data, e_data);
    check("event_o", 32'(event_w), 32'(e_event));
    check("full_o", 32'(full_w), 32'(e_full));
    update  = 1'b0;
    ctrl.rd = 1'b0;
  endtask

  // ---------------- directed + random sequence ----------------
  initial begin
    int pushed;
    logic upd, rd;
    n_checks = 0;
    n_pass   = 0;
    ctrl     = '0;
    rst_n    = 1'b0;
    update   = 1'b0;
    val      = '0;
    step(0, 0, 0, 0, 16'h0);
    step(0, 0, 0, 0, 16'h0);
    check("reset_valid", 32'(reply.valid), 32'h0);
    check("reset_full", 32'(full_w), 32'h0);

    // empty status, underflow read, udf visible
    step(1, 0, 0, 1, A_STA);
    check("tp1_stat_empty", reply.data, 32'h00010000);
    step(1, 0, 0, 1, A_DAT);
    check("tp1_data_empty", reply.data, 32'h00001244);
    step(1, 0, 0, 1, A_STA);
    check("tp1_stat_udf", reply.data, 32'h00090000);

    // three pushes, event once, in-order pops
    step(1, 1, 16'hA, 0, 16'h0);
    check("tp2_event_first", 32'(event_w), 32'h1);
    step(1, 1, 16'hB, 0, 16'h0);
    check("tp2_event_second", 32'(event_w), 32'h0);
    step(1, 1, 16'hC, 0, 16'h0);
    step(1, 0, 0, 1, A_DAT);
    check("tp2_pop_a", reply.data, 32'hA);
    step(1, 0, 0, 1, A_DAT);
    check("tp2_pop_b", reply.data, 32'hB);
    step(1, 0, 0, 1, A_DAT);
    check("tp2_pop_c", reply.data, 32'hC);
    step(1, 0, 0, 1, A_STA);
    check("tp2_stat_final", reply.data, 32'h00010000);

    // overflow: push 1..5 into 4 entries
    for (int i = 1; i <= 5; i++) step(1, 1, 16'(i), 0, 16'h0);
    check("tp3_full", 32'(full_w), 32'h1);
    step(1, 0, 0, 1, A_STA);
    check("tp3_stat_ovf", reply.data, 32'h00060004);
    for (int i = 1; i <= 4; i++) begin
      step(1, 0, 0, 1, A_DAT);
      check("tp3_pop", reply.data, 32'(i));
    end
    step(1, 0, 0, 1, A_STA);
    check("tp3_stat_cleared", reply.data, 32'h00010000);
`ifdef BISET_STATUS_FIFO_DROPCNT_EN
    step(1, 0, 0, 1, A_DRP);
    check("tp3_dropcnt_one", reply.data, 32'h1);
    step(1, 0, 0, 1, A_DRP);
    check("tp3_dropcnt_zero", reply.data, 32'h0);
`else
    step(1, 0, 0, 1, A_DRP);
    check("tp3_addr2_undecoded", 32'(reply.valid), 32'h0);
`endif

    // full FIFO with simultaneous push and pop
    for (int i = 0; i < 4; i++) step(1, 1, 16'(16'h10 + i), 0, 16'h0);
    step(1, 1, 16'h55, 1, A_DAT);
    check("tp4_pop_head", reply.data, 32'h10);
    step(1, 0, 0, 1, A_STA);
    check("tp4_stat", reply.data, 32'h00020004);
    for (int i = 0; i < 4; i++) step(1, 0, 0, 1, A_DAT);
    check("tp4_last_pop", reply.data, 32'h55);

    // 300 interleaved pushes/pops across pointer wrap, no flags
    pushed = 0;
    for (int c = 0; c < 5000 && (pushed < 300 || exp_q.size() > 0); c++) begin
      rd  = (exp_q.size() > 0) && ($urandom_range(0, 1) == 1);
      upd = (pushed < 300) && ($urandom_range(0, 1) == 1) && (exp_q.size() < DEPTH || rd);
      if (upd) pushed++;
      step(1, upd, 16'($urandom), rd, A_DAT);
    end
    step(1, 0, 0, 1, A_STA);
    check("tp5_stat_clean", reply.data, 32'h00010000);

    // reset with entries queued and a read in flight
    for (int i = 0; i < 3; i++) step(1, 1, 16'($urandom), 0, 16'h0);
    step(0, 0, 0, 1, A_DAT);
    check("tp6_no_reply", 32'(reply.valid), 32'h0);
    check("tp6_event", 32'(event_w), 32'h0);
    step(1, 0, 0, 1, A_STA);
    check("tp6_stat", reply.data, 32'h00010000);

    // fully random traffic: all addresses, overflow, underflow, rare resets
    for (int c = 0; c < 600; c++) begin
      logic [15:0] a;
      a = ($urandom_range(0, 9) == 0) ? 16'h0007 : 16'(ADDR + $urandom_range(0, 3));
      step(($urandom_range(0, 99) != 0), 1'($urandom_range(0, 1)), 16'($urandom),
           1'($urandom_range(0, 1)), a);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/biset_status_fifo.md
Name: biset_status_fifo

Overview:
- Parametrised successor of the single-entry BiSet status register.
- Captures a value from local logic into a DEPTH-entry FIFO on every update pulse.
- Exposes the FIFO to the BiSet bus: reading the data address pops the head entry; reading the status address returns fill level and flags.
- Sits beside other BiSet slaves; its reply feeds the BiSet reply mux.

Parameters:
- ADDR, 0, BiSet base address; occupies ADDR (data) and ADDR+1 (status), plus ADDR+2 when the optional feature is enabled.
- WIDTH, 32, captured value width; 1..32, zero-extended to 32 bits on the bus.
- DEPTH, 4, FIFO entries; power of two, 2..256.
- RESET, 0, value returned on a data read while the FIFO is empty.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-low.
- val_i  in  WIDTH  value to capture.
- update_i  in  1  capture strobe; one entry per high cycle.
- event_o  out  1  one-cycle pulse when the FIFO goes from empty to non-empty.
- full_o  out  1  FIFO full, registered.
- setCtrl_i  in  BiSet::biSetCtrl  BiSet control (address, read strobe).
- setReply_o  out  BiSet::biSetReply  BiSet reply (valid, data).

Behaviour:
- Reset (rst_i low at a clock edge):
  - Read and write pointers and count go to 0.
  - event_o=0, full_o=0, reply invalid with data 0.
  - Reset dominates every other event in the same cycle.
- Storage: circular buffer with pointers of clog2(DEPTH) bits that wrap naturally; count is clog2(DEPTH)+1 bits.
- Push:
  - Occurs when update_i=1 and the FIFO is not full; val_i is written at the write pointer.
  - update_i while full with no pop in the same cycle: the value is dropped and the sticky ovf flag is set.
- Pop:
  - Occurs on a BiSet read of ADDR when count>0.
  - Reply data is the head entry, zero-extended; the read pointer then advances.
  - Data read while empty: reply data is RESET, no pointer change, sticky udf flag is set.
- Simultaneous push and pop:
  - Both take effect and count is unchanged.
  - When full, the push is accepted because the pop frees the slot; no ovf.
  - When empty, the pop sees empty (returns RESET, sets udf) and the push is stored. No bypass.
- Status read of ADDR+1, data layout:
  - bits[15:0] = count.
  - bit16 = empty, bit17 = full.
  - bit18 = ovf, bit19 = udf.
  - Reading clears ovf and udf in the following cycle. A new overflow or underflow in the read cycle keeps its flag set.
- BiSet writes to any of these addresses are ignored; this block drives no write response.
- Reply timing:
  - Registered, one cycle after the read strobe: valid=1 for exactly one cycle, data as above.
  - Reply is invalid with data 0 when the block is not addressed, so the reply mux can OR-combine replies.
- event_o: registered; high for one cycle after the cycle in which count goes 0->1.
- full_o: registered, equals (count==DEPTH).
- Reads on consecutive cycles are accepted back to back; each one pops.

Optional Feature:
- Macro: BISET_STATUS_FIFO_DROPCNT_EN.
- With the macro defined:
  - A 16-bit saturating counter of dropped pushes is added.
  - Readable at ADDR+2; reading returns the count and clears it to 0 in the next cycle.
  - A drop in the same cycle as the read leaves the counter at 1.
  - Reset value 0.
- Without the macro: ADDR+2 is not decoded and no counter logic exists; ovf is still present.

Decomposition:
- BiSet package gains:
  - status-word bit-position constants: COUNT_LSB=0, EMPTY_BIT=16, FULL_BIT=17, OVF_BIT=18, UDF_BIT=19;
  - a BiSetFifoStatus packed-struct typedef for the status word.
- One sub-module: biset_fifo_core, a generic synchronous FIFO (push, pop, data, count, full, empty), parametrised by WIDTH and DEPTH.
- biset_status_fifo itself holds the bus decode, sticky flags, reply register and optional counter.

Test Plan:
- Reset, then read ADDR+1 -> data 0x00010000 (empty). Read ADDR with RESET=0x1244 -> 0x1244, then ADDR+1 shows udf: 0x00090000.
- Push 0xA,0xB,0xC on three cycles -> event_o pulses once, one cycle after the first push. Three reads of ADDR return 0xA, 0xB, 0xC in order; final status count=0.
- DEPTH=4, push 5 values 1..5 -> full_o=1 and status 0x00060004. Reads return 1..4; the status read clears ovf to 0x00010000 in the next status read. With the macro, ADDR+2 reads 1, then 0.
- Full FIFO, update_i and a data read in the same cycle -> pop returns the head entry, the new value is stored, count stays 4, ovf stays 0.
- Push/pop 300 entries with DEPTH=4, interleaved -> data order preserved across pointer wrap, no flags set.
- rst_i low for one cycle with 3 entries queued and a read in flight -> no reply valid in the next cycle, status reads 0x00010000, event_o=0.
